// File: rtl/filter_ctrl.sv
// Sequencer for a time-multiplexed FIR: circular sample buffer in external RAM,
// one shared MAC over all taps. Define FILTER_SAT_EN for a saturating accumulator.
module filter_ctrl #(
   parameter int TAPS = 16,
   parameter int AW   = 4,
   parameter int DW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   output logic                 smp_we,
   output logic [AW-1:0]        smp_waddr,
   output logic [DW-1:0]        smp_wdata,
   output logic [AW-1:0]        smp_raddr,
   input  logic [DW-1:0]        smp_rdata,
   output logic [AW-1:0]        coef_addr,
   input  logic [DW-1:0]        coef_data,
   output logic [31:0]          y,
   output logic                 y_valid,
   input  logic                 y_ready
);

   // state | meaning
   // CLR   | zero the sample RAM, one address per cycle
   // IDLE  | ready for a sample; write it and start a pass
   // MAC   | issue TAPS reads, then drain the last product
   // OUT   | hold result until consumer accepts
   typedef enum logic [1:0] {S_CLR, S_IDLE, S_MAC, S_OUT} state_t;

   localparam logic [AW:0]   K_END   = (AW+1)'(TAPS);
   localparam logic [AW-1:0] CLR_END = AW'(TAPS-1);

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_cnt;
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     base;
   logic [AW:0]       k;
   logic              prod_vld;
   logic [31:0]       acc;
   logic [31:0]       acc_sum;
   logic [31:0]       y_reg;
   logic              hs;
   logic              mac_issue;
   logic              mac_done;

   logic signed [2*DW-1:0] prod;
   logic signed [31:0]     prod_ext;

   assign hs        = (state == S_IDLE) && in_valid;
   assign mac_issue = (state == S_MAC) && (k != K_END);
   assign mac_done  = (state == S_MAC) && (k == K_END);

   assign prod     = $signed(smp_rdata) * $signed(coef_data);
   assign prod_ext = 32'(prod);

`ifdef FILTER_SAT_EN
   logic [32:0] sum_wide;

   always_comb begin
      sum_wide = {acc[31], acc} + {prod_ext[31], prod_ext};
      acc_sum  = sum_wide[31:0];
      // Sign bits disagree only when the 32-bit result left the representable range.
      if (sum_wide[32] != sum_wide[31])
         acc_sum = sum_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   end
`else
   always_comb begin
      acc_sum = acc + prod_ext;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_CLR;
         clr_cnt  <= '0;
         wptr     <= '0;
         base     <= '0;
         k        <= '0;
         prod_vld <= 1'b0;
         acc      <= '0;
         y_reg    <= '0;
      end else begin
         state    <= state_nxt;
         prod_vld <= mac_issue;
         if (state == S_CLR)
            clr_cnt <= clr_cnt + 1'b1;
         if (hs) begin
            base <= wptr;
            wptr <= wptr + 1'b1;
            acc  <= '0;
            k    <= '0;
         end else begin
            if (prod_vld)
               acc <= acc_sum;
            if (mac_issue)
               k <= k + 1'b1;
         end
         // The final product arrives in the drain cycle, so fold it in directly.
         if (mac_done)
            y_reg <= acc_sum;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_CLR:  if (clr_cnt == CLR_END) state_nxt = S_IDLE;
         S_IDLE: if (hs)                 state_nxt = S_MAC;
         S_MAC:  if (mac_done)           state_nxt = S_OUT;
         S_OUT:  if (y_ready)            state_nxt = S_IDLE;
         default:                        state_nxt = S_CLR;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      // Gate with rst so the clear sweep does not write while reset is held.
      smp_we    = ((state == S_CLR) && !rst) || hs;
      smp_waddr = (state == S_CLR) ? clr_cnt : wptr;
      smp_wdata = (state == S_IDLE) ? in_data : '0;
      smp_raddr = '0;
      coef_addr = '0;
      if (state == S_MAC) begin
         smp_raddr = base - k[AW-1:0];
         coef_addr = k[AW-1:0];
      end
      y       = y_reg;
      y_valid = (state == S_OUT);
   end

endmodule

// File: doc/filter_ctrl.md
# filter_ctrl

Time-multiplexed sequencer for the FIR filter datapath: accepts input samples over a valid/ready handshake, maintains a circular sample buffer in external RAM, sequences a single shared multiply-accumulate over all taps, and presents the 32-bit result `y` over a valid/ready handshake. It sits between the sample source (ADC/FFT front end) and the filter output consumer, owning the RAM/ROM address generation and the MAC schedule.

## Interface
- `TAPS`, 16, number of filter taps (power of two, ≥2)
- `AW`, 4, address width, log2(`TAPS`)
- `DW`, 16, sample/coefficient width, signed two's complement
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  input sample valid
- `in_data`  in  DW  input sample
- `in_ready`  out  1  controller can accept a sample
- `smp_we`  out  1  sample RAM write enable
- `smp_waddr`  out  AW  sample RAM write address
- `smp_wdata`  out  DW  sample RAM write data
- `smp_raddr`  out  AW  sample RAM read address
- `smp_rdata`  in  DW  sample RAM read data, 1-cycle registered latency
- `coef_addr`  out  AW  coefficient ROM address
- `coef_data`  in  DW  coefficient ROM data, 1-cycle registered latency
- `y`  out  32  filter output
- `y_valid`  out  1  output valid
- `y_ready`  in  1  consumer accepts output

## Operation
- States: CLR → IDLE → MAC → OUT → IDLE.
- CLR (entered on reset): writes 0 to RAM addresses 0..TAPS-1, one per cycle; `in_ready`=0; then IDLE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`: `smp_we`=1 (combinational), `smp_waddr`=`wptr`, `smp_wdata`=`in_data`; latch `base`=`wptr`; `wptr` increments mod TAPS; accumulator cleared; go MAC.
- MAC: counter k=0..TAPS-1, one read per cycle: `smp_raddr`=(`base`−k) mod TAPS, `coef_addr`=k. Data returning one cycle later is multiplied (DW×DW signed → 2·DW, sign-extended to 32) and added to the accumulator. After the last product is added, `y`←accumulator, go OUT.
- OUT: `y_valid`=1, `y` stable. On `y_valid`&&`y_ready`: go IDLE.
- `in_ready`=0 in CLR, MAC, OUT; no input is accepted while a result is pending.
- Result: y[n] = Σ_{k=0}^{TAPS-1} coef[k]·x[n−k].
- Accumulator: 32-bit, wraps modulo 2^32 (see Configuration).

## Timing
- Reset values: `in_ready`=0, `smp_we`=0, `smp_waddr`=0, `smp_wdata`=0, `smp_raddr`=0, `coef_addr`=0, `y`=0, `y_valid`=0, `wptr`=0, state=CLR.
- CLR lasts exactly TAPS cycles after `rst` deasserts; `in_ready` first high on cycle TAPS+1.
- Handshake in cycle H: reads issued H+1..H+TAPS, products added H+2..H+TAPS+1, `y_valid` high from H+TAPS+2.
- Output accept in cycle A: `y_valid` low and `in_ready` high at A+1. Minimum sample period TAPS+3 cycles.
- `wptr` wraps TAPS-1 → 0; read addresses wrap below 0 to TAPS-1.
- `y_ready` high while `y_valid` low: ignored.
- `rst` asserted in any state: all outputs return to reset values immediately; the in-flight computation is discarded; CLR re-runs.

## Configuration
- `FILTER_SAT_EN` defined: each accumulate is evaluated at 33 bits and clamped to 0x7FFFFFFF / 0x80000000; accumulation continues from the clamped value.
- Undefined: plain 32-bit wrap-around addition.

## Test plan
- Reset/clear: release `rst` → `smp_we`=1 for 16 cycles, `smp_waddr` 0..15, data 0; `in_ready` rises on cycle 17; `y`=0, `y_valid`=0 throughout.
- Impulse: coef[k]=k+1, samples 1,0,0,… with `y_ready`=1 → `y`=1,2,…,16 then 0; `y_valid` 18 cycles after each input handshake.
- Backpressure: hold `y_ready`=0 for 5 cycles in OUT → `y` and `y_valid` stable, `in_ready`=0, `in_valid` ignored; accept then `in_ready`=1 next cycle.
- Wrap: all coef=1, 20 samples of value 1 → `y`=1..16, then 16 for samples 17–20; `smp_waddr` wraps 15→0.
- Overflow: all samples and coefs 0x7FFF → `y`=0xFFF00010 without `FILTER_SAT_EN`, 0x7FFFFFFF with it.
- Mid-MAC reset: assert `rst` at k=7 → outputs zero the same cycle; after release, full 16-cycle CLR, then the next sample computes from a zeroed buffer.
